pipeline_ex_muldiv: RTL and testbench
=====================================

// Module: pipeline_ex_muldiv
// PURPOSE
//  Next-generation EX stage: register-operand forwarding, immediate/shamt operand select, an
//  iterative multiply/divide unit with HI/LO registers and an EX/MEM result register.
//  Sits between ID/EX and EX/MEM. Drives operands to the external ALU and takes its result back.
//  Asserts stall to the hazard unit while a mul/div result is not yet available.
// PARAMETERS
//  WIDTH    32  datapath width (>=16; immediate is 16 bits and is extended to WIDTH)
//  SHAMT_W  5   shift-amount width, zero-extended to WIDTH
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        synchronous, active-high
//  ex_valid     in   1        EX holds a real instruction
//  ex_flush     in   1        kill EX instruction this cycle
//  ForwardA/B   in   2        0=ID/EX reg, 1=MEM/WB, 2=EX/MEM, 3=zero
//  MEMWBdata    in   WIDTH    MEM/WB forward value
//  EXMEMdata    in   WIDTH    EX/MEM forward value
//  EX_dataA/B   in   WIDTH    register values from ID/EX
//  EX_ALUSrc1   in   1        1: operand A = shamt
//  EX_ALUSrc2   in   1        1: operand B = extended immediate
//  EX_EXTOp     in   1        1: sign-extend imm, 0: zero-extend
//  EX_LUOp      in   1        1: operand B = {imm,0}
//  EX_imm       in   16       immediate
//  EX_shamt     in   SHAMT_W  shift amount
//  EX_MDOp      in   3        pipeline_pkg::md_op_e (NONE,MULT,MULTU,DIV,DIVU,MFHI,MFLO,MTHI/MTLO)
//  alu_opA/B    out  WIDTH    operands to ALU (combinational)
//  alu_result   in   WIDTH    ALU result
//  stall        out  1        hold IF/ID/EX; EX/MEM gets bubble
//  md_busy      out  1        iterative op in flight
//  EXMEM_result out  WIDTH    registered EX result
//  EXMEM_valid  out  1        registered valid
// BEHAVIOUR
//  Reset: EXMEM_result=0, EXMEM_valid=0, HI=LO=0, md_busy=0, counter=0; any in-flight op aborted.
//  Forwarding applies to register values BEFORE source select (imm/shamt never overridden).
//  ForwardA/B=3 -> register operand 0.
//  alu_opA = ALUSrc1 ? zext(shamt) : fwdA.
//  alu_opB = ALUSrc2 ? (LUOp ? {imm, zeros} : EXTOp ? sext(imm) : zext(imm)) : fwdB.
//  Issue condition go = ex_valid & ~ex_flush & ~stall.
//  Start: MULT/MULTU/DIV/DIVU issue on go; operands are the forwarded register values A and B.
//   md_busy=1 from the next cycle for exactly WIDTH cycles, then HI/LO written and md_busy=0.
//  Algorithms: radix-2 shift-add multiply (full 2*WIDTH product; HI=upper, LO=lower).
//   Restoring divide (LO=quotient, HI=remainder).
//  Signed ops: operate on magnitudes, fix signs at the end; remainder takes the dividend's sign.
//  Divide by zero: LO=all ones, HI=dividend. Signed MIN/-1: LO=MIN, HI=0.
//  stall = ex_valid & ~ex_flush & md_busy & (EX_MDOp != NONE); non-md instructions flow.
//  MFHI/MFLO: result = HI/LO. MTHI/MTLO: HI/LO <= forwarded A at issue.
//  EX result = alu_result unless MFHI/MFLO. EXMEM_* updated every cycle:
//   valid = go, result = EX result (result holds its value when valid=0).
//  Latency: 1 cycle EX->EXMEM; mul/div result visible to MFHI/MFLO WIDTH+1 cycles after issue.
//  ex_flush never aborts an in-flight mul/div (it is older, already committed).
//  ex_flush and stall together: flush wins, stall=0.
//  Back-to-back md ops: the second one stalls until md_busy falls, then issues that cycle.
// STRUCTURE
//  pipeline_pkg: md_op_e encoding, FWD_* constants (FWD_IDEX=0, FWD_MEMWB=1, FWD_EXMEM=2, FWD_ZERO=3).
//  Sub-module pipeline_muldiv_iter: start/op/a/b in; busy, hi, lo out.
//   Holds the counter ($clog2(WIDTH)+1 bits) and the 2*WIDTH shift register.
//  Top: forwarding/select muxes, HI/LO write mux, result mux, EX/MEM register.
// TESTING
//  1 Forwarding: dataA=5, EXMEMdata=9, ForwardA=2, ALUSrc1=0 -> alu_opA=9.
//    ALUSrc1=1, shamt=3 -> alu_opA=3 regardless of ForwardA.
//  2 Immediate: imm=16'h8001: EXTOp=1 -> opB=32'hFFFF8001; EXTOp=0 -> 32'h00008001;
//    LUOp=1 -> 32'h80010000.
//  3 MULT -3*7: md_busy 32 cycles; MFLO issued next cycle stalls until done.
//    Then EXMEM_result=32'hFFFFFFEB, MFHI -> 32'hFFFFFFFF.
//  4 DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 7/0 -> LO=32'hFFFFFFFF, HI=7.
//    DIV 32'h80000000/-1 -> LO=32'h80000000, HI=0.
//  5 MULTU busy, then ADD issued -> no stall, EXMEM_valid=1.
//    ex_flush on a stalled MFHI -> stall=0, EXMEM_valid=0, MULTU still completes.
//  6 reset asserted at cycle 10 of DIVU -> next cycle md_busy=0, HI=LO=0, EXMEM_valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the EX stage and its multiply/divide unit.
package pipeline_pkg;

    // Mul/div opcode carried down the pipe with each instruction.
    // MTHI and MTLO share MdMt; bit 1 of the immediate (funct 0x11 vs 0x13) picks the target.
    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMfhi  = 3'd5,
        MdMflo  = 3'd6,
        MdMt    = 3'd7
    } md_op_e;

    // Forwarding mux selects.
    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;
    localparam logic [1:0] FWD_ZERO  = 2'd3;

    // True for the ops that occupy the iterative unit.
    function automatic logic md_is_iter(md_op_e op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/pipeline_muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider working on operand magnitudes.
// Busy for exactly WIDTH cycles after start; done_o marks the last cycle, when hi_o/lo_o
// carry the sign-corrected result.
import pipeline_pkg::*;

module pipeline_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d, dvd_q, dvd_d;
    logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod;

    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CntW'(1));

    // Split signs off at start so the datapath only ever sees magnitudes.
    always_comb begin
        is_signed = (op_i == MdMult) || (op_i == MdDiv);
        a_neg     = is_signed & a_i[WIDTH-1];
        b_neg     = is_signed & b_i[WIDTH-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
    end

    // One shift-add (mul) or shift-subtract (div) step on {hi, lo}.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Shifted partial remainder needs WIDTH+1 bits; bit WIDTH of trial is the borrow.
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (is_div_q) begin
            if (trial[WIDTH]) begin
                acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final step; remainder follows the dividend's sign.
    always_comb begin
        prod = neg_lo_q ? -acc_step : acc_step;
        quo  = acc_step[WIDTH-1:0];
        rem  = acc_step[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end else if (div0_q) begin
            hi_o = dvd_q;
            lo_o = '1;
        end else begin
            hi_o = neg_hi_q ? -rem : rem;
            lo_o = neg_lo_q ? -quo : quo;
        end
    end

    // Load operands on start, otherwise step while busy.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        if (start_i) begin
            cnt_d    = CntW'(WIDTH);
            is_div_d = (op_i == MdDiv) || (op_i == MdDivu);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            div0_d   = (b_i == '0);
            dvd_d    = a_i;
            if (is_div_d) begin
                acc_d  = {{WIDTH{1'b0}}, a_mag};
                opnd_d = b_mag;
            end else begin
                acc_d  = {{WIDTH{1'b0}}, b_mag};
                opnd_d = a_mag;
            end
        end else if (busy_o) begin
            cnt_d = cnt_q - CntW'(1);
            acc_d = acc_step;
        end
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: rtl/pipeline_ex_muldiv.sv
// EX stage: operand forwarding and select, HI/LO with an iterative mul/div unit,
// and the EX/MEM result register.
import pipeline_pkg::*;

module pipeline_ex_muldiv #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic               ex_flush,
    input  logic [1:0]         ForwardA,
    input  logic [1:0]         ForwardB,
    input  logic [WIDTH-1:0]   MEMWBdata,
    input  logic [WIDTH-1:0]   EXMEMdata,
    input  logic [WIDTH-1:0]   EX_dataA,
    input  logic [WIDTH-1:0]   EX_dataB,
    input  logic               EX_ALUSrc1,
    input  logic               EX_ALUSrc2,
    input  logic               EX_EXTOp,
    input  logic               EX_LUOp,
    input  logic [15:0]        EX_imm,
    input  logic [SHAMT_W-1:0] EX_shamt,
    input  md_op_e             EX_MDOp,
    output logic [WIDTH-1:0]   alu_opA,
    output logic [WIDTH-1:0]   alu_opB,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               stall,
    output logic               md_busy,
    output logic [WIDTH-1:0]   EXMEM_result,
    output logic               EXMEM_valid
);
    logic [WIDTH-1:0] fwd_a, fwd_b, imm_ext, ex_result;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] exmem_result_q, exmem_result_d;
    logic             exmem_valid_q, exmem_valid_d;
    logic             go, md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    // Forwarding acts on register values only; imm/shamt are selected afterwards.
    always_comb begin
        case (ForwardA)
            FWD_IDEX:  fwd_a = EX_dataA;
            FWD_MEMWB: fwd_a = MEMWBdata;
            FWD_EXMEM: fwd_a = EXMEMdata;
            default:   fwd_a = '0;
        endcase
        case (ForwardB)
            FWD_IDEX:  fwd_b = EX_dataB;
            FWD_MEMWB: fwd_b = MEMWBdata;
            FWD_EXMEM: fwd_b = EXMEMdata;
            default:   fwd_b = '0;
        endcase
    end

    // Immediate extension and ALU source select.
    always_comb begin
        if (EX_LUOp) begin
            imm_ext = WIDTH'(EX_imm) << (WIDTH - 16);
        end else if (EX_EXTOp) begin
            imm_ext = WIDTH'($signed(EX_imm));
        end else begin
            imm_ext = WIDTH'(EX_imm);
        end
        alu_opA = EX_ALUSrc1 ? WIDTH'(EX_shamt) : fwd_a;
        alu_opB = EX_ALUSrc2 ? imm_ext : fwd_b;
    end

    // Any md op waits for the unit; a flush kills the instruction and drops the stall.
    assign stall    = ex_valid & ~ex_flush & md_busy & (EX_MDOp != MdNone);
    assign go       = ex_valid & ~ex_flush & ~stall;
    assign md_start = go & md_is_iter(EX_MDOp);

    pipeline_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (md_start),
        .op_i    (EX_MDOp),
        .a_i     (fwd_a),
        .b_i     (fwd_b),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // HI/LO write: unit completion, or MTHI/MTLO (never both, md ops stall while busy).
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (go && (EX_MDOp == MdMt)) begin
            if (EX_imm[1]) begin
                lo_d = fwd_a;
            end else begin
                hi_d = fwd_a;
            end
        end
    end

    // EX result mux and EX/MEM next state; result holds across bubbles.
    always_comb begin
        case (EX_MDOp)
            MdMfhi:  ex_result = hi_q;
            MdMflo:  ex_result = lo_q;
            default: ex_result = alu_result;
        endcase
        exmem_valid_d  = go;
        exmem_result_d = go ? ex_result : exmem_result_q;
    end

    // HI/LO and EX/MEM registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q           <= '0;
            lo_q           <= '0;
            exmem_result_q <= '0;
            exmem_valid_q  <= 1'b0;
        end else begin
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            exmem_result_q <= exmem_result_d;
            exmem_valid_q  <= exmem_valid_d;
        end
    end

    assign EXMEM_result = exmem_result_q;
    assign EXMEM_valid  = exmem_valid_q;

endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
// Self-checking bench for pipeline_ex_muldiv with a result scoreboard and a mul/div model.
module tb_pipeline_ex_muldiv;
    import pipeline_pkg::*;

    localparam int unsigned W = 32;

    logic         clk, reset, ex_valid, ex_flush;
    logic [1:0]   ForwardA, ForwardB;
    logic [W-1:0] MEMWBdata, EXMEMdata, EX_dataA, EX_dataB;
    logic         EX_ALUSrc1, EX_ALUSrc2, EX_EXTOp, EX_LUOp;
    logic [15:0]  EX_imm;
    logic [4:0]   EX_shamt;
    md_op_e       EX_MDOp;
    logic [W-1:0] alu_opA, alu_opB, alu_result, EXMEM_result;
    logic         stall, md_busy, EXMEM_valid;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] sb[$];

    pipeline_ex_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MEMWBdata(MEMWBdata), .EXMEMdata(EXMEMdata),
        .EX_dataA(EX_dataA), .EX_dataB(EX_dataB), .EX_ALUSrc1(EX_ALUSrc1),
        .EX_ALUSrc2(EX_ALUSrc2), .EX_EXTOp(EX_EXTOp), .EX_LUOp(EX_LUOp), .EX_imm(EX_imm),
        .EX_shamt(EX_shamt), .EX_MDOp(EX_MDOp), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_result(alu_result), .stall(stall), .md_busy(md_busy),
        .EXMEM_result(EXMEM_result), .EXMEM_valid(EXMEM_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_flush = 1'b0; EX_MDOp = MdNone;
        ForwardA = FWD_IDEX; ForwardB = FWD_IDEX;
        EX_ALUSrc1 = 1'b0; EX_ALUSrc2 = 1'b0; EX_EXTOp = 1'b0; EX_LUOp = 1'b0;
        EX_imm = '0; EX_shamt = '0;
    endtask

    // Drive one instruction, wait out its stall (bounded), let it issue, capture EX/MEM.
    task automatic issue(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [15:0] imm, input logic [W-1:0] alu,
                         output logic v, output logic [W-1:0] r, output int stalls);
        EX_MDOp = op; EX_dataA = a; EX_dataB = b; EX_imm = imm; alu_result = alu;
        ex_valid = 1'b1;
        stalls = 0;
        #1;
        while (stall === 1'b1 && stalls < 200) begin
            tick();
            stalls++;
        end
        tick();
        v = EXMEM_valid;
        r = EXMEM_result;
        idle();
    endtask

    // Count cycles until md_busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (md_busy === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // Reference HI/LO for the iterative ops.
    task automatic model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint          sa, sb_;
        longint unsigned ua, ub, p;
        int              qa, qb;
        sa = longint'($signed(a)); sb_ = longint'($signed(b));
        ua = {32'h0, a}; ub = {32'h0, b};
        hi = '0; lo = '0;
        case (op)
            MdMult: begin p = longint'(sa * sb_); hi = p[63:32]; lo = p[31:0]; end
            MdMultu: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            MdDiv: begin
                if (b == '0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin qa = $signed(a); qb = $signed(b); lo = qa / qb; hi = qa % qb; end
            end
            MdDivu: begin
                if (b == '0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        logic v; logic [W-1:0] r, e; int s;
        reset = 1'b1; idle(); alu_result = '0;
        EX_dataA = '0; EX_dataB = '0; MEMWBdata = '0; EXMEMdata = '0;
        tick(); tick();
        n_tests++;
        if (EXMEM_valid !== 1'b0 || EXMEM_result !== '0) begin
            n_fail++;
            $display("FAIL reset_exmem: valid=%b result=%h want 0/0", EXMEM_valid, EXMEM_result);
        end
        n_tests++;
        if (md_busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: md_busy=%b stall=%b want 0/0", md_busy, stall);
        end
        reset = 1'b0;
        tick();
        sb.push_back('0);
        issue(MdMfhi, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL reset_hi: valid=%b got %h want %h", v, r, e);
        end
        sb.push_back('0);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL reset_lo: valid=%b got %h want %h", v, r, e);
        end
    endtask

    task automatic test_forwarding();
        logic v; logic [W-1:0] r, e; int s;
        EX_dataA = 32'd5; EX_dataB = 32'd6; EXMEMdata = 32'd9; MEMWBdata = 32'd11;
        for (int fa = 0; fa < 4; fa++) begin
            ForwardA = 2'(fa); EX_ALUSrc1 = 1'b0; #1;
            case (fa)
                0: e = 32'd5;
                1: e = 32'd11;
                2: e = 32'd9;
                default: e = '0;
            endcase
            n_tests++;
            if (alu_opA !== e) begin
                n_fail++; $display("FAIL fwd_a sel=%0d: got %h want %h", fa, alu_opA, e);
            end
            EX_ALUSrc1 = 1'b1; EX_shamt = 5'd3; #1;
            n_tests++;
            if (alu_opA !== 32'd3) begin
                n_fail++; $display("FAIL shamt sel=%0d: got %h want 00000003", fa, alu_opA);
            end
        end
        idle(); ForwardB = FWD_EXMEM; #1;
        n_tests++;
        if (alu_opB !== 32'd9) begin
            n_fail++; $display("FAIL fwd_b: got %h want 00000009", alu_opB);
        end
        tick();
        ForwardB = FWD_EXMEM;
        sb.push_back(32'h1234_5678);
        issue(MdNone, 32'd5, 32'd6, '0, 32'h1234_5678, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL alu_flow: valid=%b got %h want %h", v, r, e);
        end
    endtask

    task automatic test_immediate();
        logic [15:0]  imms[4] = '{16'h8001, 16'h8001, 16'h8001, 16'h7FFF};
        logic         exts[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         lus[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] exps[4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'h0000_7FFF};
        EX_dataB = 32'h0BAD_0BAD; ForwardB = FWD_EXMEM;
        for (int i = 0; i < 4; i++) begin
            EX_ALUSrc2 = 1'b1; EX_imm = imms[i]; EX_EXTOp = exts[i]; EX_LUOp = lus[i]; #1;
            n_tests++;
            if (alu_opB !== exps[i]) begin
                n_fail++; $display("FAIL imm case %0d: got %h want %h", i, alu_opB, exps[i]);
            end
        end
        EX_ALUSrc2 = 1'b0; ForwardB = FWD_IDEX; #1;
        n_tests++;
        if (alu_opB !== 32'h0BAD_0BAD) begin
            n_fail++; $display("FAIL imm_off: got %h want 0bad0bad", alu_opB);
        end
        idle();
        tick();
    endtask

    task automatic test_mult();
        logic v; logic [W-1:0] r, e; int s;
        sb.push_back(32'h0000_C0DE);
        issue(MdMult, 32'hFFFF_FFFD, 32'd7, '0, 32'h0000_C0DE, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e || md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_issue: valid=%b got %h want %h busy=%b", v, r, e, md_busy);
        end
        sb.push_back(32'hFFFF_FFEB);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        n_tests++;
        if (s != int'(W)) begin
            n_fail++; $display("FAIL mflo_stall: stalled %0d cycles want %0d", s, W);
        end
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL mult_lo: valid=%b got %h want %h", v, r, e);
        end
        sb.push_back(32'hFFFF_FFFF);
        issue(MdMfhi, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL mult_hi: valid=%b got %h want %h", v, r, e);
        end
    endtask

    // Runs one iterative op to completion and checks busy length, LO and HI against the model.
    task automatic run_and_check(input md_op_e op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input string tag);
        logic v; logic [W-1:0] r, e, mh, ml; int s, c;
        model(op, a, b, mh, ml);
        issue(op, a, b, '0, '0, v, r, s);
        wait_idle(c);
        n_tests++;
        if (c != int'(W)) begin
            n_fail++; $display("FAIL %s busy: %0d cycles want %0d", tag, c, W);
        end
        sb.push_back(ml);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL %s lo a=%h b=%h: got %h want %h", tag, a, b, r, e);
        end
        sb.push_back(mh);
        issue(MdMfhi, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL %s hi a=%h b=%h: got %h want %h", tag, a, b, r, e);
        end
    endtask

    task automatic test_div();
        md_op_e       ops[4] = '{MdDiv, MdDivu, MdDiv, MdDiv};
        logic [W-1:0] as[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [W-1:0] bs[4]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) run_and_check(ops[i], as[i], bs[i], "div");
    endtask

    task automatic test_random();
        md_op_e op; logic [W-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = md_op_e'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            run_and_check(op, a, b, "rand");
        end
    endtask

    task automatic test_flow_flush();
        logic v; logic [W-1:0] r, e; int s, c;
        issue(MdMultu, 32'd5, 32'd6, '0, '0, v, r, s);
        EX_MDOp = MdNone; ex_valid = 1'b1; alu_result = 32'h0000_ABCD; #1;
        n_tests++;
        if (stall !== 1'b0 || md_busy !== 1'b1) begin
            n_fail++; $display("FAIL add_no_stall: stall=%b busy=%b want 0/1", stall, md_busy);
        end
        sb.push_back(32'h0000_ABCD);
        tick();
        e = sb.pop_front(); n_tests++;
        if (EXMEM_valid !== 1'b1 || EXMEM_result !== e) begin
            n_fail++;
            $display("FAIL add_flow: valid=%b got %h want %h", EXMEM_valid, EXMEM_result, e);
        end
        EX_MDOp = MdMfhi; ex_valid = 1'b1; ex_flush = 1'b0; alu_result = 32'h1111_1111; #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL mfhi_stall: stall=%b want 1", stall);
        end
        ex_flush = 1'b1; #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: stall=%b want 0", stall);
        end
        tick();
        n_tests++;
        if (EXMEM_valid !== 1'b0 || EXMEM_result !== 32'h0000_ABCD || md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_bubble: valid=%b result=%h busy=%b want 0/0000abcd/1",
                     EXMEM_valid, EXMEM_result, md_busy);
        end
        idle();
        wait_idle(c);
        n_tests++;
        if (c != int'(W) - 2) begin
            n_fail++; $display("FAIL flush_busy: %0d more cycles want %0d", c, W - 2);
        end
        sb.push_back(32'd30);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL multu_lo: valid=%b got %h want %h", v, r, e);
        end
    endtask

    task automatic test_reset_mid();
        logic v; logic [W-1:0] r, e; int s;
        issue(MdDivu, 32'd100, 32'd7, '0, '0, v, r, s);
        for (int i = 0; i < 9; i++) tick();
        n_tests++;
        if (md_busy !== 1'b1) begin
            n_fail++; $display("FAIL divu_cycle10: busy=%b want 1", md_busy);
        end
        reset = 1'b1; ex_valid = 1'b1; EX_MDOp = MdNone; alu_result = 32'h77;
        tick();
        reset = 1'b0; idle();
        n_tests++;
        if (md_busy !== 1'b0 || EXMEM_valid !== 1'b0 || EXMEM_result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%h want 0/0/0",
                     md_busy, EXMEM_valid, EXMEM_result);
        end
        tick();
        sb.push_back('0);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL reset_mid_lo: valid=%b got %h want %h", v, r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic v; logic [W-1:0] r, e; int s, c;
        issue(MdMult, 32'd4, 32'd5, '0, '0, v, r, s);
        issue(MdDivu, 32'd9, 32'd2, '0, '0, v, r, s);
        n_tests++;
        if (s != int'(W) || v !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stall: stalled %0d valid=%b want %0d/1", s, v, W);
        end
        wait_idle(c);
        sb.push_back(32'd4);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e || c != int'(W)) begin
            n_fail++; $display("FAIL b2b_lo: got %h want %h busy %0d", r, e, c);
        end
    endtask

    task automatic test_mt();
        logic v; logic [W-1:0] r, e; int s;
        EXMEMdata = 32'h99; ForwardA = FWD_EXMEM;
        issue(MdMt, 32'd5, '0, 16'h0011, '0, v, r, s);
        issue(MdMt, 32'h66, '0, 16'h0013, '0, v, r, s);
        sb.push_back(32'h99);
        issue(MdMfhi, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL mthi: got %h want %h", r, e);
        end
        sb.push_back(32'h66);
        issue(MdMflo, '0, '0, '0, 32'hDEAD_BEEF, v, r, s);
        e = sb.pop_front(); n_tests++;
        if (v !== 1'b1 || r !== e) begin
            n_fail++; $display("FAIL mtlo: got %h want %h", r, e);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_immediate();
        test_mult();
        test_div();
        test_flow_flush();
        test_reset_mid();
        test_back_to_back();
        test_mt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
